// File: rtl/qdec_pkg.sv
// Shared types and Gray-code step helpers for the quadrature decoder.
// Optional build flag QDEC_VELOCITY_EN enables per-channel step period measurement.
package qdec_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    QDEC_X1,
    QDEC_X2,
    QDEC_X4,
    QDEC_RSVD
  } qdec_mode_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } qdec_step_t;

  function automatic logic [1:0] gray_next(
    input logic [1:0] ab,
    input logic       fwd
  );
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = fwd ? 2'b10 : 2'b01;
      2'b10:   nxt = fwd ? 2'b11 : 2'b00;
      2'b11:   nxt = fwd ? 2'b01 : 2'b10;
      default: nxt = fwd ? 2'b00 : 2'b11;
    endcase
    return nxt;
  endfunction

  function automatic qdec_step_t qdec_step(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    qdec_step_t s;
    if (cur == prev)
      s = STEP_NONE;
    else if (cur == gray_next(prev, 1'b1))
      s = STEP_FWD;
    else if (cur == gray_next(prev, 1'b0))
      s = STEP_REV;
    else
      s = STEP_ILL;
    return s;
  endfunction

endpackage

// File: rtl/qdec_if.sv
// Encoder pin / channel status bundle shared by the top, channels and bench.
// Width follows NUM_CH so one instance can carry a single channel or all of them.
interface qdec_if #(
  parameter int NUM_CH = 4,
  parameter int POS_W  = 32
);
  logic [NUM_CH-1:0]       a;
  logic [NUM_CH-1:0]       b;
  logic [NUM_CH-1:0]       z;
  logic [NUM_CH-1:0]       clear;
  logic [NUM_CH*POS_W-1:0] position;
  logic [NUM_CH-1:0]       direction;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       homed;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH*POS_W-1:0] period;

  modport master (
    output a, b, z, clear,
    input  position, direction, trigger, homed, err, period
  );

  modport slave (
    input  a, b, z, clear,
    output position, direction, trigger, homed, err, period
  );
endinterface

// File: rtl/qdec_channel.sv
// One encoder channel: sync, debounce, x1/x2/x4 decode, homing, delta trigger.
// QDEC_VELOCITY_EN adds a saturating step-period counter.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int POS_W  = 32,
  parameter int DBNC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  qdec_mode_t        mode,
  input  logic [DBNC_W-1:0] dbnc_time,
  input  logic [POS_W-1:0]  zero_position,
  input  logic [POS_W-1:0]  delta_size,
  qdec_if.slave             bus
);

  logic [SYNC_STAGES-1:0] a_sync, b_sync, z_sync;
  logic [1:0]             ab_sync, ab_next, ab_acc;
  logic                   z_now, z_next, z_acc;
  logic [DBNC_W-1:0]      ab_cnt, z_cnt;
  logic                   ab_take, z_take, z_home;
  logic                   a_chg, mode_ok, fwd, count;
  qdec_step_t             step;
  logic signed [POS_W-1:0] dc, dc_next, dsz;
  logic                   hit;

  assign ab_sync = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
  assign ab_next = {a_sync[SYNC_STAGES-2], b_sync[SYNC_STAGES-2]};
  assign z_now   = z_sync[SYNC_STAGES-1];
  assign z_next  = z_sync[SYNC_STAGES-2];

  assign ab_take = enable && (ab_cnt == dbnc_time) && (ab_sync != ab_acc);
  assign z_take  = enable && (z_cnt == dbnc_time) && (z_now != z_acc);
  assign z_home  = z_take && z_now && !bus.homed[0];

  // Counters clear on the edge where the synced value changes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
      z_sync <= '0;
      ab_cnt <= '0;
      z_cnt  <= '0;
      ab_acc <= '0;
      z_acc  <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], bus.a[0]};
      b_sync <= {b_sync[SYNC_STAGES-2:0], bus.b[0]};
      z_sync <= {z_sync[SYNC_STAGES-2:0], bus.z[0]};
      if (!enable || ab_next != ab_sync)
        ab_cnt <= '0;
      else if (ab_cnt != dbnc_time)
        ab_cnt <= ab_cnt + 1'b1;
      if (!enable || z_next != z_now)
        z_cnt <= '0;
      else if (z_cnt != dbnc_time)
        z_cnt <= z_cnt + 1'b1;
      if (!enable || ab_take)
        ab_acc <= ab_sync;
      if (!enable || z_take)
        z_acc <= z_now;
    end
  end

  always_comb begin
    step    = qdec_step(ab_acc, ab_sync);
    a_chg   = ab_acc[1] ^ ab_sync[1];
    fwd     = (step == STEP_FWD);
    mode_ok = 1'b1;
    case (mode)
      QDEC_X1: mode_ok = a_chg & ~ab_sync[0];
      QDEC_X2: mode_ok = a_chg;
      default: mode_ok = 1'b1;
    endcase
    count   = ab_take && (fwd || step == STEP_REV) && mode_ok;
    dsz     = delta_size;
    dc_next = fwd ? dc + 1'b1 : dc - 1'b1;
    hit     = (dsz != '0) && (dc_next == dsz || dc_next == -dsz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.position  <= '0;
      bus.direction <= '0;
      bus.trigger   <= '0;
      bus.homed     <= '0;
      bus.err       <= '0;
      dc            <= '0;
    end else if (bus.clear[0]) begin
      bus.position  <= '0;
      bus.direction <= '0;
      bus.trigger   <= '0;
      bus.homed     <= '0;
      bus.err       <= '0;
      dc            <= '0;
    end else begin
      bus.trigger <= '0;
      if (ab_take && step == STEP_ILL)
        bus.err <= 1'b1;
      if (z_home) begin
        bus.position <= zero_position;
        bus.homed    <= 1'b1;
        dc           <= '0;
      end else if (count) begin
        bus.position  <= fwd ? bus.position + 1'b1
                             : bus.position - 1'b1;
        bus.direction <= fwd;
        if (hit) begin
          bus.trigger <= 1'b1;
          dc          <= '0;
        end else begin
          dc <= dc_next;
        end
      end
    end
  end

`ifdef QDEC_VELOCITY_EN
  logic [POS_W-1:0] per_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.clear[0]) begin
      per_cnt    <= '0;
      bus.period <= '0;
    end else if (enable) begin
      if (count && !z_home) begin
        bus.period <= (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
        per_cnt    <= '0;
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + 1'b1;
      end
    end
  end
`else
  assign bus.period = '0;
`endif

endmodule

// File: rtl/quad_decoder_mc.sv
// Multi-channel quadrature decoder: one qdec_channel per axis plus packing.
// Build flag QDEC_VELOCITY_EN enables o_period; otherwise it reads 0.
module quad_decoder_mc
  import qdec_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int POS_W  = 32,
  parameter int DBNC_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH-1:0]       i_a,
  input  logic [NUM_CH-1:0]       i_b,
  input  logic [NUM_CH-1:0]       i_z,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic [DBNC_W-1:0]       i_dbnc_time,
  input  logic [POS_W-1:0]        i_zero_position,
  input  logic [POS_W-1:0]        i_delta_size,
  input  logic [NUM_CH-1:0]       i_clear,
  output logic [NUM_CH*POS_W-1:0] o_position,
  output logic [NUM_CH-1:0]       o_direction,
  output logic [NUM_CH-1:0]       o_trigger,
  output logic [NUM_CH-1:0]       o_homed,
  output logic [NUM_CH-1:0]       o_err,
  output logic [NUM_CH*POS_W-1:0] o_period
);

  qdec_mode_t mode;
  assign mode = qdec_mode_t'(i_mode);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    qdec_if #(.NUM_CH(1), .POS_W(POS_W)) cif ();

    assign cif.a     = i_a[n];
    assign cif.b     = i_b[n];
    assign cif.z     = i_z[n];
    assign cif.clear = i_clear[n];

    qdec_channel #(
      .POS_W (POS_W),
      .DBNC_W(DBNC_W)
    ) u_ch (
      .clk          (i_clk),
      .rst          (i_reset),
      .enable       (i_enable),
      .mode         (mode),
      .dbnc_time    (i_dbnc_time),
      .zero_position(i_zero_position),
      .delta_size   (i_delta_size),
      .bus          (cif.slave)
    );

    assign o_position[n*POS_W +: POS_W] = cif.position;
    assign o_period[n*POS_W +: POS_W]   = cif.period;
    assign o_direction[n]               = cif.direction[0];
    assign o_trigger[n]                 = cif.trigger[0];
    assign o_homed[n]                   = cif.homed[0];
    assign o_err[n]                     = cif.err[0];
  end

endmodule

// File: tb/tb_quad_decoder_mc.sv
// Directed self-checking bench for quad_decoder_mc.
// Expected values are hand-derived from the encoder step sequences applied.
module tb_quad_decoder_mc;
  localparam int NUM_CH = 4;
  localparam int POS_W  = 32;
  localparam int DBNC_W = 16;
  localparam logic [POS_W-1:0] ONES = '1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable;
  logic [1:0]        mode;
  logic [DBNC_W-1:0] dbnc;
  logic [POS_W-1:0]  zpos, dsize;
  logic [1:0]        st [NUM_CH];
  int                n_checks = 0;
  int                n_fail   = 0;

  qdec_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) bus ();

  quad_decoder_mc #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .DBNC_W(DBNC_W)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_a            (bus.a),
    .i_b            (bus.b),
    .i_z            (bus.z),
    .i_enable       (enable),
    .i_mode         (mode),
    .i_dbnc_time    (dbnc),
    .i_zero_position(zpos),
    .i_delta_size   (dsize),
    .i_clear        (bus.clear),
    .o_position     (bus.position),
    .o_direction    (bus.direction),
    .o_trigger      (bus.trigger),
    .o_homed        (bus.homed),
    .o_err          (bus.err),
    .o_period       (bus.period)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [POS_W-1:0] pos(input int ch);
    return bus.position[ch*POS_W +: POS_W];
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] s, input logic f);
    case (s)
      2'b00:   return f ? 2'b10 : 2'b01;
      2'b10:   return f ? 2'b11 : 2'b00;
      2'b11:   return f ? 2'b01 : 2'b10;
      default: return f ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic drive(input int ch, input logic [1:0] v);
    st[ch]    = v;
    bus.a[ch] = v[1];
    bus.b[ch] = v[0];
  endtask

  task automatic step(input int ch, input logic f);
    drive(ch, nxt(st[ch], f));
    tick(3);
  endtask

  task automatic clr(input logic [NUM_CH-1:0] m);
    bus.clear = m;
    tick(1);
    bus.clear = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (bus.position !== '0) begin
      n_fail++; $display("FAIL reset_pos: got %0h exp 0", bus.position);
    end
    n_checks++;
    if (bus.direction !== '0) begin
      n_fail++; $display("FAIL reset_dir: got %0h exp 0", bus.direction);
    end
    n_checks++;
    if (bus.trigger !== '0) begin
      n_fail++; $display("FAIL reset_trig: got %0h exp 0", bus.trigger);
    end
    n_checks++;
    if (bus.homed !== '0) begin
      n_fail++; $display("FAIL reset_homed: got %0h exp 0", bus.homed);
    end
    n_checks++;
    if (bus.err !== '0) begin
      n_fail++; $display("FAIL reset_err: got %0h exp 0", bus.err);
    end
    n_checks++;
    if (bus.period !== '0) begin
      n_fail++; $display("FAIL reset_period: got %0h exp 0", bus.period);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_home_x4;
    mode = 2'd2;
    dbnc = '0;
    zpos = 32'd100;
    bus.z[0] = 1'b1;
    tick(2);
    n_checks++;
    if (bus.homed[0] !== 1'b0) begin
      n_fail++; $display("FAIL home_early: got %b exp 0", bus.homed[0]);
    end
    tick(1);
    n_checks++;
    if (bus.homed[0] !== 1'b1 || pos(0) !== 32'd100) begin
      n_fail++;
      $display("FAIL home: homed %b pos %0d exp 1 100", bus.homed[0], pos(0));
    end
    bus.z[0] = 1'b0;
    tick(3);
    for (int i = 1; i <= 8; i++) begin
      drive(0, nxt(st[0], 1'b1));
      tick(2);
      n_checks++;
      if (pos(0) !== 32'(100 + i - 1)) begin
        n_fail++; $display("FAIL step_early%0d: got %0d exp %0d", i, pos(0), 100 + i - 1);
      end
      tick(1);
      n_checks++;
      if (pos(0) !== 32'(100 + i)) begin
        n_fail++; $display("FAIL step_lat%0d: got %0d exp %0d", i, pos(0), 100 + i);
      end
    end
    n_checks++;
    if (bus.direction[0] !== 1'b1) begin
      n_fail++; $display("FAIL x4_dir: got %b exp 1", bus.direction[0]);
    end
`ifdef QDEC_VELOCITY_EN
    n_checks++;
    if (bus.period[POS_W-1:0] !== 32'd3) begin
      n_fail++; $display("FAIL period: got %0d exp 3", bus.period[POS_W-1:0]);
    end
`else
    n_checks++;
    if (bus.period !== '0) begin
      n_fail++; $display("FAIL period_off: got %0h exp 0", bus.period);
    end
`endif
    bus.z[0] = 1'b1;
    tick(4);
    bus.z[0] = 1'b0;
    tick(3);
    n_checks++;
    if (pos(0) !== 32'd108) begin
      n_fail++; $display("FAIL z_reuse: got %0d exp 108", pos(0));
    end
  endtask

  task automatic test_x1_x2;
    mode = 2'd0;
    clr(4'b0001);
    n_checks++;
    if (pos(0) !== '0 || bus.homed[0] !== 1'b0) begin
      n_fail++; $display("FAIL clear_home: pos %0d homed %b exp 0 0", pos(0), bus.homed[0]);
    end
    repeat (32) step(0, 1'b1);
    repeat (12) step(0, 1'b0);
    n_checks++;
    if (pos(0) !== 32'd5 || bus.direction[0] !== 1'b0) begin
      n_fail++; $display("FAIL x1: pos %0d dir %b exp 5 0", pos(0), bus.direction[0]);
    end
    clr(4'b0001);
    mode = 2'd1;
    repeat (32) step(0, 1'b1);
    repeat (12) step(0, 1'b0);
    n_checks++;
    if (pos(0) !== 32'd10 || bus.direction[0] !== 1'b0) begin
      n_fail++; $display("FAIL x2: pos %0d dir %b exp 10 0", pos(0), bus.direction[0]);
    end
  endtask

  task automatic test_delta;
    clr(4'b0001);
    mode  = 2'd2;
    dsize = 32'd4;
    for (int i = 1; i <= 10; i++) begin
      step(0, 1'b1);
      n_checks++;
      if (bus.trigger[0] !== (i == 4 || i == 8)) begin
        n_fail++; $display("FAIL trig_fwd%0d: got %b", i, bus.trigger[0]);
      end
    end
    for (int j = 1; j <= 6; j++) begin
      step(0, 1'b0);
      n_checks++;
      if (bus.trigger[0] !== (j == 6)) begin
        n_fail++; $display("FAIL trig_rev%0d: got %b", j, bus.trigger[0]);
      end
    end
    n_checks++;
    if (pos(0) !== 32'd4) begin
      n_fail++; $display("FAIL delta_pos: got %0d exp 4", pos(0));
    end
    dsize = '0;
  endtask

  task automatic test_debounce;
    clr(4'b0001);
    dbnc = 16'd5;
    drive(0, 2'b10);
    tick(3);
    drive(0, 2'b00);
    tick(12);
    n_checks++;
    if (pos(0) !== '0) begin
      n_fail++; $display("FAIL glitch: got %0d exp 0", pos(0));
    end
    drive(0, 2'b10);
    tick(7);
    n_checks++;
    if (pos(0) !== '0) begin
      n_fail++; $display("FAIL dbnc_early: got %0d exp 0", pos(0));
    end
    tick(1);
    n_checks++;
    if (pos(0) !== 32'd1) begin
      n_fail++; $display("FAIL dbnc_held: got %0d exp 1", pos(0));
    end
    dbnc = '0;
    tick(2);
  endtask

  task automatic test_illegal;
    step(0, 1'b1);
    drive(0, 2'b00);
    tick(4);
    n_checks++;
    if (bus.err[0] !== 1'b1 || pos(0) !== 32'd2 || bus.direction[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal: err %b pos %0d dir %b exp 1 2 1",
               bus.err[0], pos(0), bus.direction[0]);
    end
    clr(4'b0001);
    n_checks++;
    if (bus.err[0] !== 1'b0 || pos(0) !== '0) begin
      n_fail++; $display("FAIL err_clear: err %b pos %0d exp 0 0", bus.err[0], pos(0));
    end
  endtask

  task automatic test_wrap_enable;
    logic seen;
    step(0, 1'b0);
    n_checks++;
    if (pos(0) !== ONES || bus.direction[0] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_dn: pos %0h dir %b exp ffffffff 0", pos(0), bus.direction[0]);
    end
    step(0, 1'b1);
    n_checks++;
    if (pos(0) !== '0) begin
      n_fail++; $display("FAIL wrap_up: got %0h exp 0", pos(0));
    end
    dsize  = 32'd1;
    enable = 1'b0;
    seen   = 1'b0;
    repeat (3) begin
      drive(0, nxt(st[0], 1'b1));
      repeat (3) begin
        tick(1);
        seen |= bus.trigger[0];
      end
    end
    enable = 1'b1;
    repeat (6) begin
      tick(1);
      seen |= bus.trigger[0];
    end
    n_checks++;
    if (pos(0) !== '0 || seen !== 1'b0) begin
      n_fail++; $display("FAIL disabled: pos %0d trig %b exp 0 0", pos(0), seen);
    end
    step(0, 1'b1);
    n_checks++;
    if (pos(0) !== 32'd1 || bus.trigger[0] !== 1'b1) begin
      n_fail++; $display("FAIL reenable: pos %0d trig %b exp 1 1", pos(0), bus.trigger[0]);
    end
    dsize = '0;
    tick(1);
  endtask

  task automatic test_channels;
    clr(4'b1111);
    zpos = 32'd100;
    drive(1, nxt(st[1], 1'b1));
    drive(2, nxt(st[2], 1'b0));
    bus.z[3] = 1'b1;
    tick(3);
    n_checks++;
    if (pos(1) !== 32'd1 || pos(2) !== ONES || pos(3) !== 32'd100 || pos(0) !== '0) begin
      n_fail++;
      $display("FAIL multi_pos: %0h %0h %0h %0h exp 0 1 ffffffff 64",
               pos(0), pos(1), pos(2), pos(3));
    end
    n_checks++;
    if (bus.homed !== 4'b1000 || bus.direction !== 4'b0010) begin
      n_fail++;
      $display("FAIL multi_flags: homed %b dir %b exp 1000 0010", bus.homed, bus.direction);
    end
  endtask

  initial begin
    enable    = 1'b1;
    mode      = 2'd2;
    dbnc      = '0;
    zpos      = '0;
    dsize     = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.z     = '0;
    bus.clear = '0;
    for (int i = 0; i < NUM_CH; i++) st[i] = 2'b00;
    test_reset();
    test_home_x4();
    test_x1_x2();
    test_delta();
    test_debounce();
    test_illegal();
    test_wrap_enable();
    test_channels();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
